// File: rtl/snake_uart_pkg.sv
// rtl/snake_uart_pkg.sv - shared types, tick constants and baud divider helper for the UART link
package snake_uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

    // Tick index of the last tick in a 16-tick bit, and of the mid-start-bit sample
    localparam logic [3:0] LAST_TICK  = 4'd15;
    localparam logic [3:0] START_TICK = 4'd7;

    // Clocks per 16x oversampling tick, rounded to nearest, never below one
    function automatic int calc_div(input int clk_hz, input int baud);
        int d;
        d = (clk_hz + 8 * baud) / (16 * baud);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/snake_uart_fifo.sv
// rtl/snake_uart_fifo.sv - first-word-fall-through FIFO with full/empty flags
module snake_uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_pop;
    logic             do_push;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    // A pop in the same cycle frees the slot, so a full FIFO still takes the push
    assign do_push = push_i && (!full_o || do_pop);
    // Head is forced to zero while empty so the output is defined straight out of reset
    assign pop_data_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    // Pointer update; the extra MSB distinguishes full from empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage write; contents are don't-care until pointed at by a valid entry
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end

endmodule

// File: rtl/snake_uart_link.sv
// rtl/snake_uart_link.sv - full-duplex buffered UART link for the board-to-board player channel
module snake_uart_link
    import snake_uart_pkg::*;
#(
    parameter int CLK_HZ     = 75_000_000,
    parameter int BAUD       = 115_200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic                 tx,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err,
    output logic                 rx_overflow,
    input  logic                 err_clr
);
    localparam int         DIV       = calc_div(CLK_HZ, BAUD);
    localparam int         DW        = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic       PAR_EN    = (PARITY != int'(PAR_NONE));
    localparam logic       PAR_INV   = (PARITY == int'(PAR_ODD));
    localparam logic [3:0] LAST_BIT  = 4'(DATA_BITS - 1);
    localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

    logic [DW-1:0]        div_cnt_q;
    logic                 tick;
    logic                 tx_full, tx_empty, tx_load, tx_bit_end;
    logic [DATA_BITS-1:0] tx_head, tx_shift_q;
    uart_state_e          tx_state_q;
    logic [3:0]           tx_tcnt_q, tx_bit_q;
    logic                 tx_stop_q, tx_par_q, tx_q;
    logic                 rx_meta_q, rx_sync_q, rx_prev_q;
    uart_state_e          rx_state_q;
    logic [3:0]           rx_tcnt_q, rx_bit_q;
    logic [DATA_BITS-1:0] rx_shift_q;
    logic                 rx_par_q, rx_done_q, rx_stop_ok_q, rx_par_bad_q, rx_push_q;
    logic                 rx_sample, rx_full, rx_empty;
    logic                 frame_err_q, parity_err_q, overflow_q;

    assign tick          = (div_cnt_q == DW'(DIV - 1));
    assign tx            = tx_q;
    assign tx_ready      = !tx_full;
    assign rx_valid      = !rx_empty;
    assign rx_frame_err  = frame_err_q;
    assign rx_parity_err = parity_err_q;
    assign rx_overflow   = overflow_q;

    // Shared 16x oversampling tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) div_cnt_q <= '0;
        else        div_cnt_q <= tick ? '0 : div_cnt_q + DW'(1);
    end

    snake_uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .rst_n(rst_n),
        .push_i(tx_valid), .push_data_i(tx_data), .pop_i(tx_load),
        .pop_data_o(tx_head), .full_o(tx_full), .empty_o(tx_empty)
    );

    // A word is loaded from IDLE at once, or at the end of the last stop bit for back-to-back frames
    assign tx_bit_end = tick && (tx_tcnt_q == LAST_TICK);
    assign tx_load    = !tx_empty && ((tx_state_q == ST_IDLE) ||
                        (tx_state_q == ST_STOP && tx_bit_end && tx_stop_q == LAST_STOP));

    // TX FSM; tx follows the state one clock later so every bit is a whole number of ticks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= ST_IDLE;
            tx_tcnt_q  <= '0;
            tx_bit_q   <= '0;
            tx_stop_q  <= 1'b0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            tx_tcnt_q <= tx_load ? 4'd0 : (tick ? tx_tcnt_q + 4'd1 : tx_tcnt_q);
            case (tx_state_q)
                ST_IDLE: tx_q <= 1'b1;
                ST_START: begin
                    tx_q <= 1'b0;
                    if (tx_bit_end) begin
                        tx_state_q <= ST_DATA;
                        tx_bit_q   <= '0;
                    end
                end
                ST_DATA: begin
                    tx_q <= tx_shift_q[0];
                    if (tx_bit_end) begin
                        tx_shift_q <= tx_shift_q >> 1;
                        tx_bit_q   <= tx_bit_q + 4'd1;
                        tx_stop_q  <= 1'b0;
                        if (tx_bit_q == LAST_BIT) tx_state_q <= PAR_EN ? ST_PARITY : ST_STOP;
                    end
                end
                ST_PARITY: begin
                    tx_q <= tx_par_q;
                    if (tx_bit_end) tx_state_q <= ST_STOP;
                end
                ST_STOP: begin
                    tx_q <= 1'b1;
                    if (tx_bit_end) begin
                        if (tx_stop_q == LAST_STOP) tx_state_q <= ST_IDLE;
                        else                        tx_stop_q  <= 1'b1;
                    end
                end
                default: tx_state_q <= ST_IDLE;
            endcase
            if (tx_load) begin
                tx_state_q <= ST_START;
                tx_shift_q <= tx_head;
                tx_par_q   <= (^tx_head) ^ PAR_INV;
            end
        end
    end

    // Two-stage synchroniser plus edge-detect history, idle-high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // First sample lands mid start bit, later ones a full bit apart
    assign rx_sample = tick && (rx_tcnt_q == ((rx_state_q == ST_START) ? START_TICK : LAST_TICK));

    // RX FSM; the parity accumulator ends at zero for a correct frame in either parity sense
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q   <= ST_IDLE;
            rx_tcnt_q    <= '0;
            rx_bit_q     <= '0;
            rx_shift_q   <= '0;
            rx_par_q     <= 1'b0;
            rx_done_q    <= 1'b0;
            rx_stop_ok_q <= 1'b0;
            rx_par_bad_q <= 1'b0;
            rx_push_q    <= 1'b0;
        end else begin
            rx_done_q <= 1'b0;
            rx_push_q <= rx_done_q && rx_stop_ok_q && !rx_par_bad_q;
            if (rx_state_q == ST_IDLE) rx_tcnt_q <= '0;
            else if (tick)             rx_tcnt_q <= rx_sample ? 4'd0 : rx_tcnt_q + 4'd1;
            case (rx_state_q)
                ST_IDLE: if (rx_prev_q && !rx_sync_q) rx_state_q <= ST_START;
                ST_START: if (rx_sample) begin
                    rx_state_q <= rx_sync_q ? ST_IDLE : ST_DATA;
                    rx_bit_q   <= '0;
                    rx_par_q   <= PAR_INV;
                end
                ST_DATA: if (rx_sample) begin
                    rx_shift_q <= {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
                    rx_par_q   <= rx_par_q ^ rx_sync_q;
                    rx_bit_q   <= rx_bit_q + 4'd1;
                    if (rx_bit_q == LAST_BIT) rx_state_q <= PAR_EN ? ST_PARITY : ST_STOP;
                end
                ST_PARITY: if (rx_sample) begin
                    rx_par_q   <= rx_par_q ^ rx_sync_q;
                    rx_state_q <= ST_STOP;
                end
                ST_STOP: if (rx_sample) begin
                    rx_done_q    <= 1'b1;
                    rx_stop_ok_q <= rx_sync_q;
                    rx_par_bad_q <= rx_par_q && PAR_EN;
                    rx_state_q   <= ST_IDLE;
                end
                default: rx_state_q <= ST_IDLE;
            endcase
        end
    end

    // Shift register is stable until the next frame's data bits, so it feeds the FIFO directly
    snake_uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .rst_n(rst_n),
        .push_i(rx_push_q), .push_data_i(rx_shift_q), .pop_i(rx_ready),
        .pop_data_o(rx_data), .full_o(rx_full), .empty_o(rx_empty)
    );

    // Sticky error flags; a clear wins over a same-cycle set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else if (err_clr) begin
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            if (rx_done_q && !rx_stop_ok_q)           frame_err_q  <= 1'b1;
            if (rx_done_q && rx_par_bad_q)            parity_err_q <= 1'b1;
            if (rx_push_q && rx_full && !rx_ready)    overflow_q   <= 1'b1;
        end
    end

endmodule

// File: doc/snake_uart_link.md
# snake_uart_link

Parametrised full-duplex UART link for the board-to-board player channel: serialises outgoing game messages onto `tx` and deserialises `rx` into a receive queue. Both directions are buffered by FIFOs and use valid/ready handshakes toward the game core. Adds configurable frame format, 16x-oversampled receive, error detection and overflow reporting. Sits between the game core and the PMOD pins, in the same clock domain as the game core.

## Interface
- `CLK_HZ`, 75_000_000, core clock frequency
- `BAUD`, 115_200, line rate
- `DATA_BITS`, 8, payload bits per frame (5..9)
- `PARITY`, 0, 0 = none, 1 = even, 2 = odd
- `STOP_BITS`, 1, 1 or 2 (transmit); receive checks the first stop bit only
- `FIFO_DEPTH`, 16, entries per direction, power of two, >= 2
- `clk`  in  1  core clock; one clock
- `rst_n`  in  1  asynchronous, active-low reset
- `rx`  in  1  serial input, asynchronous to `clk`
- `tx`  out  1  serial output
- `tx_data`  in  DATA_BITS  byte to send
- `tx_valid`  in  1  `tx_data` offered
- `tx_ready`  out  1  TX FIFO not full
- `rx_data`  out  DATA_BITS  head of RX FIFO (first-word-fall-through)
- `rx_valid`  out  1  RX FIFO not empty
- `rx_ready`  in  1  consumer pops head
- `rx_frame_err`  out  1  sticky: stop bit sampled low
- `rx_parity_err`  out  1  sticky: parity mismatch
- `rx_overflow`  out  1  sticky: frame completed while RX FIFO full
- `err_clr`  in  1  clears all sticky flags

## Operation
- Tick generator: `DIV = round(CLK_HZ / (16*BAUD))`, minimum 1; one-cycle `tick` every DIV clocks. Bit period is exactly 16 ticks.
- TX FSM states: IDLE -> START -> DATA -> PARITY (only if PARITY != 0) -> STOP -> IDLE.
  - START is skipped to directly from IDLE when the FIFO is non-empty. The word is popped on that transition.
  - DATA is LSB first, DATA_BITS bits.
  - PARITY bit is the XOR of the data bits, inverted when odd.
  - STOP holds `tx` high for STOP_BITS bit periods.
  - From STOP, the FSM goes directly to START if the FIFO is non-empty; otherwise it returns to IDLE.
- RX input: 2-FF synchroniser, both stages reset to 1.
- RX FSM states: IDLE -> START -> DATA -> PARITY (optional) -> STOP -> IDLE.
  - A falling edge in IDLE resets the tick phase counter.
  - The start bit is sampled at tick 8. If it reads high, this is a false start: return to IDLE with no flag.
  - Each subsequent bit is sampled 16 ticks after the previous sample.
- At the STOP sample:
  - Stop bit = 0: set `rx_frame_err` and drop the frame.
  - Parity mismatch: set `rx_parity_err` and drop the frame.
  - Otherwise push the frame. If the RX FIFO is full, drop it and set `rx_overflow`.
- After the STOP sample, RX returns to IDLE immediately. The remaining half stop bit is not waited out.
- FIFOs: a push is accepted when `!full || pop` in the same cycle. A pop on empty is ignored.
- `err_clr` has priority over a same-cycle flag set: the flag is clear in the next cycle and re-sets only on a later event.

## Timing
- Reset values:
  - `tx` = 1
  - `tx_ready` = 1
  - `rx_valid` = 0, `rx_data` = 0
  - all error flags = 0
  - both FSMs IDLE, FIFOs empty, tick counter 0
- TX latency: `tx_valid && tx_ready` at edge N -> `tx` falls (start bit) at edge N+2 when the FSM is in IDLE.
- Back-to-back TX frames have no idle gap beyond the stop bits.
- RX latency: `rx_valid` rises 2 clocks after the edge where the stop bit is sampled.
- `tx_ready` drops in the cycle after the push that fills the FIFO.
- Reset mid-frame: `tx` returns to 1 asynchronously and FIFO contents are discarded.

## Structure
- Package `snake_uart_pkg` holds:
  - `parity_e` enum (NONE, EVEN, ODD)
  - `uart_state_e` enum (IDLE, START, DATA, PARITY, STOP)
  - function `calc_div(clk_hz, baud)`
- Sub-module `snake_uart_fifo`: parameters WIDTH and DEPTH, first-word-fall-through, full/empty flags. It is instantiated twice.

## Test plan
- Reset: hold `rst_n` = 0 -> `tx` = 1, `tx_ready` = 1, `rx_valid` = 0, flags 0.
- Loopback (`tx` tied to `rx`), CLK_HZ = 64, BAUD = 1 (DIV = 4), 8N1: push 0xA5 -> `rx_data` = 0xA5 with `rx_valid` = 1 after 10 bit periods plus latency, no flags.
- PARITY = 2 (odd): drive frame 0x3C with even parity bit -> `rx_parity_err` = 1 and `rx_valid` stays 0. Then `err_clr` -> flag 0.
- Glitch: `rx` low for 3 clocks (less than 8 ticks) -> no frame, no flags; RX back in IDLE.
- FIFO_DEPTH = 4: send 5 frames with `rx_ready` = 0 -> 4 entries held, `rx_overflow` = 1, entries read out in order 0x01..0x04.
- Stop bit driven 0 on frame 0x55 -> `rx_frame_err` = 1, frame dropped. A following good 0x66 is received normally.
